// File: rtl/perf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : perf_pkg
// Purpose  : Shared CSR addresses, inhibit bit positions and the half-select
//            decode helper for the performance counter unit.
// Revision : 1.0 - initial release
// ============================================================================
package perf_pkg;

  // Machine-mode counter CSRs (read/write)
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  // User-mode read-only aliases
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  // Counter inhibit control
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

  localparam int CY_BIT = 0;
  localparam int IR_BIT = 2;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_LO   = 2'd1,
    SEL_HI   = 2'd2
  } cnt_sel_e;

  // Classify an address as the low half, high half, or neither of one counter
  function automatic cnt_sel_e csr_half(input logic [11:0] addr,
                                        input logic [11:0] lo_addr,
                                        input logic [11:0] hi_addr);
    if (addr == lo_addr)      return SEL_LO;
    else if (addr == hi_addr) return SEL_HI;
    else                      return SEL_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/perf_counter.sv
`default_nettype none
// ============================================================================
// Module   : perf_counter
// Purpose  : One CNT_W-bit free-running counter with 32-bit half writes and
//            a registered one-cycle wrap pulse. A write beats an increment.
// Revision : 1.0 - initial release
// ============================================================================
module perf_counter #(
  parameter int CNT_W = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc_en,
  input  logic             i_wr_lo,
  input  logic             i_wr_hi,
  input  logic [31:0]      i_wdata,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wrap
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_wrap;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_wrap_nxt;
  logic             w_unused_wdata;

  // Narrow counters leave the top write-data bits without a destination
  assign w_unused_wdata = ^i_wdata;

  // Next value: low write, high write, or increment; wrap only on increment
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_wrap_nxt = 1'b0;
    if (i_wr_lo) begin
      w_cnt_nxt[31:0] = i_wdata;
    end else if (i_wr_hi) begin
      w_cnt_nxt[CNT_W-1:32] = i_wdata[CNT_W-33:0];
    end else if (i_inc_en) begin
      w_cnt_nxt  = r_cnt + C_ONE;
      w_wrap_nxt = &r_cnt;
    end
  end

  // Counter and wrap pulse registers, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_wrap = r_wrap;

endmodule
`default_nettype wire

// File: rtl/perf_cnt_unit.sv
`default_nettype none
// ============================================================================
// Module   : perf_cnt_unit
// Purpose  : mcycle / minstret counters with combinational CSR read port,
//            mcountinhibit, and wrap pulses for debug.
//            Define PERF_CSR_WR_EN to build the CSR write path; without it
//            the counters run unconditionally and mcountinhibit reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module perf_cnt_unit #(
  parameter int CNT_W = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_insn_vld,
  input  logic [11:0]      i_csr_addr,
  input  logic             i_csr_wr_en,
  input  logic [31:0]      i_csr_wdata,
  output logic [31:0]      o_csr_rdata,
  output logic             o_csr_hit,
  output logic [CNT_W-1:0] o_cycle,
  output logic [CNT_W-1:0] o_instret,
  output logic [1:0]       o_cnt_wrap
);

  import perf_pkg::*;

  logic [CNT_W-1:0] w_cycle;
  logic [CNT_W-1:0] w_instret;
  logic [63:0]      w_cycle_ext;
  logic [63:0]      w_instret_ext;
  logic             w_cyc_wrap;
  logic             w_ins_wrap;
  logic             w_inh_cy;
  logic             w_inh_ir;
  logic             w_cyc_wr_lo;
  logic             w_cyc_wr_hi;
  logic             w_ins_wr_lo;
  logic             w_ins_wr_hi;
  logic [31:0]      w_wdata;
  logic [31:0]      w_rdata;
  logic             w_hit;

`ifdef PERF_CSR_WR_EN
  cnt_sel_e w_cyc_sel;
  cnt_sel_e w_ins_sel;
  logic     w_inh_wr;
  logic     r_inh_cy;
  logic     r_inh_ir;

  assign w_cyc_sel   = csr_half(i_csr_addr, CSR_MCYCLE, CSR_MCYCLEH);
  assign w_ins_sel   = csr_half(i_csr_addr, CSR_MINSTRET, CSR_MINSTRETH);
  assign w_cyc_wr_lo = i_csr_wr_en && (w_cyc_sel == SEL_LO);
  assign w_cyc_wr_hi = i_csr_wr_en && (w_cyc_sel == SEL_HI);
  assign w_ins_wr_lo = i_csr_wr_en && (w_ins_sel == SEL_LO);
  assign w_ins_wr_hi = i_csr_wr_en && (w_ins_sel == SEL_HI);
  assign w_inh_wr    = i_csr_wr_en && (i_csr_addr == CSR_MCOUNTINHIBIT);
  assign w_wdata     = i_csr_wdata;

  // Inhibit bits; the writing edge still counts under the old value
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_inh_cy <= 1'b0;
      r_inh_ir <= 1'b0;
    end else if (w_inh_wr) begin
      r_inh_cy <= i_csr_wdata[CY_BIT];
      r_inh_ir <= i_csr_wdata[IR_BIT];
    end
  end

  assign w_inh_cy = r_inh_cy;
  assign w_inh_ir = r_inh_ir;
`else
  logic w_unused_wr;

  assign w_unused_wr = ^{i_csr_wr_en, i_csr_wdata};
  assign w_cyc_wr_lo = 1'b0;
  assign w_cyc_wr_hi = 1'b0;
  assign w_ins_wr_lo = 1'b0;
  assign w_ins_wr_hi = 1'b0;
  assign w_wdata     = 32'd0;
  assign w_inh_cy    = 1'b0;
  assign w_inh_ir    = 1'b0;
`endif

  perf_counter #(.CNT_W(CNT_W)) u_cycle (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_inc_en (!w_inh_cy),
    .i_wr_lo  (w_cyc_wr_lo),
    .i_wr_hi  (w_cyc_wr_hi),
    .i_wdata  (w_wdata),
    .o_cnt    (w_cycle),
    .o_wrap   (w_cyc_wrap)
  );

  perf_counter #(.CNT_W(CNT_W)) u_instret (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_inc_en (i_insn_vld && !w_inh_ir),
    .i_wr_lo  (w_ins_wr_lo),
    .i_wr_hi  (w_ins_wr_hi),
    .i_wdata  (w_wdata),
    .o_cnt    (w_instret),
    .o_wrap   (w_ins_wrap)
  );

  // Zero-extend both counters to 64 bits so high-half reads above CNT_W are 0
  always_comb begin
    w_cycle_ext                = '0;
    w_instret_ext              = '0;
    w_cycle_ext[CNT_W-1:0]     = w_cycle;
    w_instret_ext[CNT_W-1:0]   = w_instret;
  end

  // CSR read mux; undecoded addresses return zero with no hit
  always_comb begin
    w_hit   = 1'b1;
    w_rdata = 32'd0;
    case (i_csr_addr)
      CSR_MCYCLE,    CSR_CYCLE:    w_rdata = w_cycle_ext[31:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   w_rdata = w_cycle_ext[63:32];
      CSR_MINSTRET,  CSR_INSTRET:  w_rdata = w_instret_ext[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: w_rdata = w_instret_ext[63:32];
      CSR_MCOUNTINHIBIT: begin
        w_rdata[CY_BIT] = w_inh_cy;
        w_rdata[IR_BIT] = w_inh_ir;
      end
      default: w_hit = 1'b0;
    endcase
  end

  assign o_csr_rdata = w_rdata;
  assign o_csr_hit   = w_hit;
  assign o_cycle     = w_cycle;
  assign o_instret   = w_instret;
  assign o_cnt_wrap  = {w_ins_wrap, w_cyc_wrap};

endmodule
`default_nettype wire

// File: doc/perf_cnt_unit.md
# perf_cnt_unit

Machine-mode cycle and retired-instruction counters for the single-cycle RV32I core. The block sits directly downstream of `insn_vld_reg` and consumes its registered `o_insn_vld`: every cycle that valid is high counts as one retired instruction. The counters are exposed through a combinational CSR read port and an optional write port. Wrap events are flagged for debug.

## Interface
Parameters:
- CNT_W, 64, counter width; legal range 33–64; CSR bits above CNT_W-1 read 0.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_insn_vld  in  1  retire strobe from `insn_vld_reg.o_insn_vld`.
- i_csr_addr  in  12  CSR address, for both read and write.
- i_csr_wr_en  in  1  CSR write strobe, sampled at the rising edge.
- i_csr_wdata  in  32  CSR write data.
- o_csr_rdata  out  32  combinational read data.
- o_csr_hit  out  1  high when i_csr_addr decodes to a CSR in this block.
- o_cycle  out  CNT_W  mcycle value.
- o_instret  out  CNT_W  minstret value.
- o_cnt_wrap  out  2  one-cycle pulse on wrap; bit0 = cycle, bit1 = instret.

## Operation
- Decoded CSRs:
  - mcycle 0xB00 and mcycleh 0xB80.
  - minstret 0xB02 and minstreth 0xB82.
  - Read-only user aliases: cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82.
  - mcountinhibit 0x320; bit0 = CY, bit2 = IR, other bits read 0.
- mcycle increments by 1 every clock edge while CY=0.
- minstret increments by 1 on every edge where i_insn_vld=1 and IR=0.
- Arithmetic is modulo 2^CNT_W. When the counter goes from all-ones to 0, the matching o_cnt_wrap bit is high for exactly the next cycle.
- A write to a low-half CSR replaces bits 31:0 and keeps the upper bits. A write to a high-half CSR replaces bits CNT_W-1:32 (truncated) and keeps bits 31:0.
- A CSR write and an increment to the same counter in the same cycle: the write wins, and there is no increment that cycle. A write never raises o_cnt_wrap.
- Writes to the 0xCxx aliases, and to undecoded addresses, are ignored.
- Undecoded read: o_csr_hit=0 and o_csr_rdata=0.

## Timing
- Reset (i_rst=0) asynchronously forces:
  - both counters = 0;
  - mcountinhibit = 0;
  - o_cnt_wrap = 0;
  - therefore o_cycle = 0, o_instret = 0, and o_csr_rdata = 0 for any address.
- Reset mid-count clears immediately, with no wait for a clock edge.
- First rising edge after reset release: mcycle = 1. minstret = 1 only if i_insn_vld was high at that edge.
- Reads are zero-latency and reflect register values from before the current edge.
- A write is visible on o_csr_rdata in the cycle after the write edge.
- A write to mcountinhibit takes effect from the next edge on; the edge that writes it still uses the old inhibit value.

## Configuration
- PERF_CSR_WR_EN defined:
  - counter and mcountinhibit writes work as described above.
- PERF_CSR_WR_EN undefined:
  - the write path is not synthesized; i_csr_wr_en and i_csr_wdata are ignored;
  - mcountinhibit reads 0 and both counters always run;
  - reads, o_csr_hit and o_cnt_wrap are unchanged.

## Structure
- Package `perf_pkg` holds:
  - the CSR address localparams;
  - the inhibit bit indices CY_BIT=0 and IR_BIT=2;
  - a `cnt_sel_e` enum for decoding low vs high half.
- Sub-module `perf_counter` is instantiated twice (cycle, instret). It contains:
  - the CNT_W register;
  - increment-enable, write-low and write-high inputs;
  - the wrap pulse output.
- The top level holds the address decode, the inhibit register and the read mux.

## Test plan
- Hold i_rst=0 with i_insn_vld=1 for 3 edges -> o_cycle=0, o_instret=0, o_csr_rdata=0 at 0xB02.
- Release reset; i_insn_vld=1 for 5 cycles, then 0 for 3 -> minstret=5, mcycle=8, instret alias 0xC02 reads 5.
- Write minstret=0xFFFF_FFFF with i_insn_vld=1 on the same edge -> reads 0xFFFF_FFFF. Next valid edge -> minstret=0, minstreth=1, o_cnt_wrap=0.
- Write mcountinhibit=0x4, then drive i_insn_vld=1 for 4 cycles -> minstret unchanged, mcycle +4. Write 0x1 -> mcycle frozen, instret counts again.
- Preload minstreth and minstret to all-ones, then one valid edge -> o_instret=0 and o_cnt_wrap=2'b10 for exactly one cycle.
- Read 0x123 -> o_csr_hit=0, o_csr_rdata=0. Write 0xC02=0x55 -> minstret unchanged. Repeat the 0xB02 write without PERF_CSR_WR_EN -> value unchanged.
